// File: rtl/spi_seq_pkg.sv
// Shared types and header-field constants for the SPI frame sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WAITB = 3'd2,
        XFER  = 3'd3,
        HOLD  = 3'd4,
        ABORT = 3'd5
    } seq_state_t;

    localparam int unsigned HDR_CS_MSB  = 7;
    localparam int unsigned HDR_CS_LSB  = 6;
    localparam int unsigned HDR_LEN_MSB = 5;
    localparam int unsigned HDR_LEN_LSB = 0;

    // FIFO entries kept free when granting CTS, covering bytes already in flight
    localparam int unsigned CTS_MARGIN  = 3;

    localparam int unsigned TMO_W       = 22;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous payload FIFO with flush; a pop on a full FIFO frees the slot for a same-cycle push.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_nxt;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata_c = mem[rd_ptr];

    // Next occupancy
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + (AW+1)'(1);
                2'b01:   count_nxt = count - (AW+1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Pointers and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Parses header+payload frames from the serial receiver and sequences SPI byte transfers under one chip select.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned CS_SETUP   = 4,
    parameter int unsigned CS_HOLD    = 4,
    parameter int unsigned TIMEOUT    = 2600000
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              rx_load,
    input  logic [7:0]        rx_byte,
    input  logic              rts,
    output logic              cts,
    output logic              spi_start,
    output logic [7:0]        spi_tx,
    input  logic              spi_busy,
    input  logic              spi_done,
    input  logic [7:0]        spi_rx,
    output logic [NUM_CS-1:0] cs_n,
    output logic              rsp_valid,
    output logic [7:0]        rsp_byte,
    input  logic              rsp_ready,
    output logic              err
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEN_W  = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int unsigned CSI_W  = HDR_CS_MSB - HDR_CS_LSB + 1;
    localparam int unsigned PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              rx_load_q;
    logic              rx_stb;
    logic [CSI_W-1:0]  hdr_cs;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_ok;
    logic [CSI_W-1:0]  cs_idx;
    logic [CSI_W-1:0]  idx_nxt;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  acc;
    logic [PH_W-1:0]   ph_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              capture;
    logic [NUM_CS-1:0] cs_n_d;
    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign rx_stb   = rx_load & ~rx_load_q;
    assign hdr_cs   = rx_byte[HDR_CS_MSB:HDR_CS_LSB];
    assign hdr_len  = rx_byte[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_ok   = (hdr_len != '0) && (32'(hdr_cs) < NUM_CS);
    assign push     = rx_stb && (state != IDLE) && (acc != '0);
    assign overflow = push & fifo_full & ~pop;
    assign capture  = (state == XFER) & spi_done;
    assign idx_nxt  = (state == IDLE) ? hdr_cs : cs_idx;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_50),
        .rst_n   (rst_n),
        .push    (push),
        .wdata   (rx_byte),
        .pop     (pop),
        .flush   (state == ABORT),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, pop decision and chip-select pattern
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cs_n_d    = '1;
        case (state)
            IDLE:  if (rx_stb && hdr_ok) state_nxt = SETUP;
            SETUP: if (ph_cnt == PH_W'(CS_SETUP - 1)) state_nxt = WAITB;
            WAITB: begin
                if (!fifo_empty && !spi_busy) begin
                    pop       = 1'b1;
                    state_nxt = XFER;
                end else if (fifo_empty && !rx_stb && tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
                    state_nxt = ABORT;
                end
            end
            XFER:  if (spi_done) state_nxt = (rem == LEN_W'(1)) ? HOLD : WAITB;
            HOLD:  if (ph_cnt == PH_W'(CS_HOLD - 1)) state_nxt = IDLE;
            ABORT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt inside {SETUP, WAITB, XFER, HOLD}) cs_n_d = ~(NUM_CS'(1) << idx_nxt);
    end

    // Frame bookkeeping: selected CS, transfers remaining, payload bytes still to accept
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_load_q <= 1'b1;
            cs_idx    <= '0;
            rem       <= '0;
            acc       <= '0;
        end else begin
            rx_load_q <= rx_load;
            if (state == IDLE && rx_stb && hdr_ok) begin
                cs_idx <= hdr_cs;
                rem    <= hdr_len;
                acc    <= hdr_len;
            end else begin
                if (capture)             rem <= rem - LEN_W'(1);
                if (push && !overflow)   acc <= acc - LEN_W'(1);
            end
        end
    end

    // Phase counter for CS setup/hold and saturating stall timer
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state_nxt != state)                    ph_cnt <= '0;
            else if (state == SETUP || state == HOLD)  ph_cnt <= ph_cnt + PH_W'(1);
            if (rx_stb || state_nxt != state)          tmo_cnt <= '0;
            else if (tmo_cnt != '1)                    tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Registered outputs towards SPI master, host and chip selects
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cts       <= 1'b0;
            spi_start <= 1'b0;
            spi_tx    <= '0;
            cs_n      <= '1;
            err       <= 1'b0;
        end else begin
            cts       <= rts & (fifo_count <= CNT_W'(FIFO_DEPTH - CTS_MARGIN));
            spi_start <= pop;
            if (pop) spi_tx <= fifo_rdata;
            cs_n      <= cs_n_d;
            err       <= overflow | (state_nxt == ABORT);
        end
    end

    // Single-entry read-back register; a new capture overwrites an unread byte
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_byte  <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_byte  <= spi_rx;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
